// File: rtl/ksa_shared_add32.sv
// Two-requester W-bit adder/subtractor built around a single 8-bit Kogge-Stone
// slice that is reused once per byte beat; round-robin arbitration, one op in flight.
module ksa_shared_add32 #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [8*WORDS-1:0]   req0_a,
    input  logic [8*WORDS-1:0]   req0_b,
    input  logic [8*WORDS-1:0]   req1_a,
    input  logic [8*WORDS-1:0]   req1_b,
    input  logic                 req0_sub,
    input  logic                 req1_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [8*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 busy
);
    localparam int W  = 8 * WORDS;
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The carry-in is folded into bit 0 as a generate so every prefix carry sees it.
    function automatic logic [8:0] ksa8(input logic [7:0] x, input logic [7:0] y,
                                        input logic cin);
        logic [7:0] p;
        logic [7:0] g;
        logic [7:0] gp;
        logic [7:0] gn;
        logic [7:0] pn;
        p    = x ^ y;
        g    = x & y;
        gp   = p;
        g[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < 8; d = d * 2) begin
            gn = g;
            pn = gp;
            for (int i = d; i < 8; i++) begin
                gn[i] = g[i] | (gp[i] & g[i-d]);
                pn[i] = gp[i] & gp[i-d];
            end
            g  = gn;
            gp = pn;
        end
        return {g[7], p ^ {g[6:0], cin}};
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic            ptr_r;
    logic [BW-1:0]   beat_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            id_r;
    logic [W-1:0]    rsp_sum_r;
    logic            rsp_cout_r;
    logic            rsp_ovf_r;

    logic            grant_any_s;
    logic            grant_id_s;
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic            sel_sub_s;
    logic [8:0]      slice_res_s;
    logic            last_beat_s;

    // Arbitration and operand selection for the requester that would be granted.
    always_comb begin
        grant_any_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ptr_r;
        end else begin
            grant_id_s = req1_valid;
        end
        if (grant_id_s) begin
            sel_a_s   = req1_a;
            sel_b_s   = req1_b;
            sel_sub_s = req1_sub;
        end else begin
            sel_a_s   = req0_a;
            sel_b_s   = req0_b;
            sel_sub_s = req0_sub;
        end
    end

    // Shared slice operates on byte lane beat_r of the latched operands.
    always_comb begin
        slice_res_s = ksa8(a_r[{beat_r, 3'b000} +: 8], b_r[{beat_r, 3'b000} +: 8], carry_r);
        last_beat_s = (beat_r == BW'(WORDS - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s) begin
                    state_s = RESP;
                end else begin
                    state_s = RUN;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode; readies are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state_r == IDLE) && grant_any_s) begin
            req0_ready = ~grant_id_s;
            req1_ready = grant_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        rsp_valid = (state_r == RESP);
        busy      = (state_r != IDLE);
        rsp_sum   = rsp_sum_r;
        rsp_cout  = rsp_cout_r;
        rsp_ovf   = rsp_ovf_r;
        rsp_id    = id_r;
    end

    // Datapath: latch on grant, one byte per RUN cycle, flags on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= 1'b0;
            beat_r     <= {BW{1'b0}};
            carry_r    <= 1'b0;
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            id_r       <= 1'b0;
            rsp_sum_r  <= {W{1'b0}};
            rsp_cout_r <= 1'b0;
            rsp_ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s ^ {W{sel_sub_s}};
                        carry_r <= sel_sub_s;
                        id_r    <= grant_id_s;
                        ptr_r   <= ~grant_id_s;
                        beat_r  <= {BW{1'b0}};
                    end
                end
                RUN: begin
                    rsp_sum_r[{beat_r, 3'b000} +: 8] <= slice_res_s[7:0];
                    carry_r <= slice_res_s[8];
                    beat_r  <= beat_r + BW'(1);
                    if (last_beat_s) begin
                        rsp_cout_r <= slice_res_s[8];
                        rsp_ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_res_s[7] != a_r[W-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ksa_shared_add32.sv
// Randomized bench for ksa_shared_add32: arbitration, latency, result/flags,
// response hold and mid-operation reset, against an arithmetic reference model.
module tb_ksa_shared_add32;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_a = 32'd0;
    logic [31:0] req0_b = 32'd0;
    logic [31:0] req1_a = 32'd0;
    logic [31:0] req1_b = 32'd0;
    logic        req0_sub = 1'b0;
    logic        req1_sub = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    bit ptr_m = 1'b0;

    always #5 clk = ~clk;

    ksa_shared_add32 #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: wide sum for carry, signed range test for overflow.
    task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                          output logic [31:0] s, output bit co, output bit ov);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        s  = sub ? (a - b) : (a + b);
        co = sub ? (a >= b) : ((64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF);
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One transaction from IDLE through response handshake; called just after a clock edge.
    task automatic txn(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input bit s0, input bit s1, input int hold);
        bit          gid;
        logic [31:0] es;
        bit          ec;
        bit          eo;
        int          n;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready = 1'b0;
        #1;
        gid = (v0 && v1) ? ptr_m : v1;
        check("ready0", 32'(req0_ready), 32'(!gid));
        check("ready1", 32'(req1_ready), 32'(gid));
        if (gid) ref_op(a1, b1, s1, es, ec, eo);
        else     ref_op(a0, b0, s0, es, ec, eo);
        ptr_m = !gid;
        @(posedge clk); #1;
        req0_a = $urandom; req0_b = $urandom; req0_sub = ($urandom_range(0, 1) == 1);
        req1_a = $urandom; req1_b = $urandom; req1_sub = ($urandom_range(0, 1) == 1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            check("busy_run", 32'(busy), 32'd1);
            check("no_ready_run", 32'({req0_ready, req1_ready}), 32'd0);
            rsp_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            n++;
        end
        rsp_ready = 1'b0;
        check("latency", 32'(n), 32'(WORDS));
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_sum", rsp_sum, es);
            check("rsp_cout", 32'(rsp_cout), 32'(ec));
            check("rsp_ovf", 32'(rsp_ovf), 32'(eo));
            check("rsp_id", 32'(rsp_id), 32'(gid));
            check("no_ready_resp", 32'({req0_ready, req1_ready}), 32'd0);
            if (h == hold) rsp_ready = 1'b1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_sum"}, rsp_sum, 32'd0);
        check({tag, "_flags"}, 32'({rsp_cout, rsp_ovf, rsp_id}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    endtask

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held valid from reset: grants must alternate 0,1,0,1.
        txn(1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        txn(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 0);
        txn(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 3);
        txn(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);

        // Reset in the middle of beat 2 aborts the operation.
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_sub = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        ptr_m = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        txn(1'b0, 1'b1, 32'd0, 32'd0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            txn((sel & 1) != 0, (sel & 2) != 0,
                pick_operand(), pick_operand(), pick_operand(), pick_operand(),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ksa_shared_add32.md
KSA_SHARED_ADD32 -- requirements
Module: ksa_shared_add32

Interface
REQ-001 Parameter: WORDS, 4, number of 8-bit beats per operation; operand width W = 8*WORDS.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid, req1_valid  in  1 each  requester i has an operation pending.
REQ-005 Port: req0_ready, req1_ready  out  1 each  operation from requester i accepted this cycle.
REQ-006 Port: req0_a, req0_b, req1_a, req1_b  in  W each  operands, unsigned/two's complement.
REQ-007 Port: req0_sub, req1_sub  in  1 each  1 = a-b, 0 = a+b.
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_ready  in  1  consumer accepts result.
REQ-010 Port: rsp_id  out  1  index of requester that issued the result.
REQ-011 Port: rsp_sum  out  W  result modulo 2^W.
REQ-012 Port: rsp_cout  out  1  carry out of bit W-1 (for sub: 1 = no borrow).
REQ-013 Port: rsp_ovf  out  1  signed overflow.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 Block SHALL contain exactly one 8-bit Kogge-Stone adder slice, time-shared across beats and requesters; slice SHALL propagate cin into every bit carry and its cout (cin treated as generate at bit -1).
REQ-016 FSM states SHALL be IDLE, RUN, RESP; no other states.
REQ-017 IDLE: if any reqi_valid, grant one requester and assert its reqi_ready combinationally that cycle; other ready stays 0; next state RUN.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant requester at priority pointer; one valid -> grant it; after any grant pointer SHALL point to the non-granted requester.
REQ-019 On grant SHALL latch a, b XOR {W{sub}}, carry register = sub, id; beat counter = 0.
REQ-020 RUN: each cycle slice adds bits [8k+7:8k] of latched a, b' with carry register; result written to rsp_sum slice k; carry register <= slice cout; k increments.
REQ-021 RUN SHALL last exactly WORDS cycles; after beat WORDS-1, rsp_cout <= final carry, rsp_ovf <= (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]); next state RESP.
REQ-022 Latency: accept in cycle T -> rsp_valid first high in cycle T+WORDS+1.
REQ-023 RESP: rsp_valid=1; rsp_sum, rsp_cout, rsp_ovf, rsp_id SHALL hold stable until rsp_valid && rsp_ready, then IDLE next cycle.
REQ-024 Requests SHALL NOT be accepted in RUN or RESP; earliest next accept is the cycle after the response handshake.
REQ-025 reqi_valid deasserting while not granted SHALL drop the request silently; request inputs SHALL be ignored after the grant cycle.
REQ-026 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, pointer to requester 0, beat counter 0, carry register 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, rsp_id 0, busy 0, req0_ready 0, req1_ready 0.
REQ-028 Reset during RUN or RESP SHALL abort the operation; no response for it is ever produced.
REQ-029 After rst_n release, first clock edge SHALL be able to accept a request.

Verification (WORDS=4)
REQ-030 req0 add a=0x000000FF b=0x00000001, accept cycle T -> rsp_valid at T+5, rsp_sum=0x00000100, cout=0, ovf=0, id=0.
REQ-031 req1 sub a=0x00000005 b=0x00000007 -> rsp_sum=0xFFFFFFFE, cout=0, ovf=0, id=1; sub a=7 b=5 -> 0x00000002, cout=1.
REQ-032 add 0x7FFFFFFF+0x00000001 -> 0x80000000, cout=0, ovf=1; add 0xFFFFFFFF+0x00000001 -> 0x00000000, cout=1, ovf=0.
REQ-033 Both requesters valid continuously from reset -> grant order 0,1,0,1; rsp_ready held low 3 cycles in RESP -> outputs stable, no new ready.
REQ-034 rst_n low during RUN beat 2 -> all outputs 0 immediately; after release, new req1 add 1+1 -> rsp_sum=0x00000002, id=1, no stale response.
